keypad_scanner: RTL and testbench

- 4x4 matrix keypad scanner and debouncer for the lock's keypad.
- Sits directly downstream of the system clock divider and consumes its one-CLK-cycle divided strobe as SCAN_TICK.
- Drives active-low keypad columns and samples active-low rows.
- Emits one KEY_VALID pulse with KEY_CODE per debounced press, which feeds the code-entry logic.

---
 rtl/locker_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 tb/tb_keypad_scanner.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/locker_pkg.sv
// Shared types and constants for the lock's keypad front end.
// Includes small helpers for row priority and column decoding.
package locker_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam int KEY_ROWS   = 4;
   localparam int KEY_COLS   = 4;
   localparam int KEY_CODE_W = 4;

   localparam logic [KEY_COLS-1:0] COL_RESET = 4'b1110;

   // Lowest-index active-low row wins when several rows are low.
   function automatic logic [1:0] lowest_low_row(input logic [KEY_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = KEY_ROWS - 1; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [KEY_COLS-1:0] cols);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < KEY_COLS; i++) begin
         if (!cols[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones
// so that idle active-low lines read as inactive.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= '1;
         Q    <= '1;
      end else begin
         meta <= D;
         Q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debouncing.
// Advances only on SCAN_TICK; emits one KEY_VALID pulse per accepted press.
module keypad_scanner
   import locker_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int CNT_WIDTH      = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  SCAN_TICK,
   input  logic [KEY_ROWS-1:0]   ROW_IN,
   output logic [KEY_COLS-1:0]   COL_OUT,
   output logic [KEY_CODE_W-1:0] KEY_CODE,
   output logic                  KEY_VALID,
   output logic                  KEY_HELD
);

   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_TICKS);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   scan_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d, cnt_inc;
   logic [1:0]            row_q, row_d;
   logic [KEY_COLS-1:0]   col_q, col_d, col_next;
   logic [KEY_CODE_W-1:0] code_q, code_d;
   logic                  valid_q, valid_d;
   logic                  held_q, held_d;
   logic [KEY_ROWS-1:0]   row_sync;
   logic                  any_low, row_low;
   logic                  accept, resume_scan;

   sync_2ff #(.WIDTH(KEY_ROWS)) u_row_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .D     (ROW_IN),
      .Q     (row_sync)
   );

   assign any_low  = ~&row_sync;
   assign row_low  = ~row_sync[row_q];
   assign cnt_inc  = count_q + CNT_ONE;
   assign col_next = {col_q[KEY_COLS-2:0], col_q[KEY_COLS-1]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= SCAN;
         count_q <= '0;
         row_q   <= '0;
         col_q   <= COL_RESET;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         row_q   <= row_d;
         col_q   <= col_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

   // The column stays frozen from press detection until release is accepted.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      row_d       = row_q;
      col_d       = col_q;
      code_d      = code_q;
      held_d      = held_q;
      valid_d     = 1'b0;
      accept      = 1'b0;
      resume_scan = 1'b0;

      if (SCAN_TICK) begin
         case (state_q)
            SCAN: begin
               if (any_low) begin
                  row_d   = lowest_low_row(row_sync);
                  count_d = CNT_ONE;
                  if (DEBOUNCE_TICKS == 1) accept = 1'b1;
                  else                     state_d = DEBOUNCE;
               end else begin
                  col_d = col_next;
               end
            end
            DEBOUNCE: begin
               if (row_low) begin
                  count_d = cnt_inc;
                  if (cnt_inc == DEB_LAST) accept = 1'b1;
               end else begin
                  resume_scan = 1'b1;
               end
            end
            HELD: begin
               if (!row_low) begin
                  count_d = CNT_ONE;
                  if (DEBOUNCE_TICKS == 1) resume_scan = 1'b1;
                  else                     state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (!row_low) begin
                  count_d = cnt_inc;
                  if (cnt_inc == DEB_LAST) resume_scan = 1'b1;
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      if (accept) begin
         code_d  = {row_d, col_index(col_q)};
         held_d  = 1'b1;
         valid_d = 1'b1;
         state_d = HELD;
      end

      if (resume_scan) begin
         held_d  = 1'b0;
         state_d = SCAN;
         col_d   = col_next;
      end
   end

   assign COL_OUT   = col_q;
   assign KEY_CODE  = code_q;
   assign KEY_VALID = valid_q;
   assign KEY_HELD  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from the
// columns, expected key codes are queued and matched by a valid monitor.
module tb_keypad_scanner;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        SCAN_TICK;
   logic [3:0]  ROW_IN;
   logic [3:0]  COL_OUT;
   logic [3:0]  KEY_CODE;
   logic        KEY_VALID;
   logic        KEY_HELD;

   logic [15:0] key_mask;
   logic [3:0]  exp_q[$];
   int          checks_total;
   int          checks_passed;
   int          valids_seen;

   always #5 CLK = ~CLK;

   keypad_scanner #(
      .DEBOUNCE_TICKS (4),
      .CNT_WIDTH      (4)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .SCAN_TICK (SCAN_TICK),
      .ROW_IN    (ROW_IN),
      .COL_OUT   (COL_OUT),
      .KEY_CODE  (KEY_CODE),
      .KEY_VALID (KEY_VALID),
      .KEY_HELD  (KEY_HELD)
   );

   // Pressed key (r,c) pulls row r low while column c is driven low.
   function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] mask);
      logic [3:0] rows;
      rows = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!cols[c] && mask[r*4+c]) rows[r] = 1'b0;
      return rows;
   endfunction

   assign ROW_IN = keypad_rows(COL_OUT, key_mask);

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      checks_total++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
      else
         checks_passed++;
   endtask

   // One SCAN_TICK spaced 4 CLK apart; returns 1 ns after the consuming edge.
   task automatic applyStimulus(input logic [15:0] mask);
      key_mask = mask;
      repeat (3) @(posedge CLK);
      #1 SCAN_TICK = 1'b1;
      @(posedge CLK);
      #1 SCAN_TICK = 1'b0;
   endtask

   task automatic monitorValid();
      logic [3:0] exp_code;
      forever begin
         @(negedge CLK);
         if (KEY_VALID === 1'b1) begin
            valids_seen++;
            if (exp_q.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL unexpected_valid: got KEY_VALID=1 code %0d expected no pulse", KEY_CODE);
            end else begin
               exp_code = exp_q.pop_front();
               checkOutput("key_code", KEY_CODE, exp_code);
            end
         end
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      valids_seen   = 0;
      RST_N         = 1'b0;
      SCAN_TICK     = 1'b0;
      key_mask      = '0;
      fork
         monitorValid();
      join_none

      // Reset and idle scan
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset_col", COL_OUT, 4'b1110);
      checkOutput("reset_valid", {3'b0, KEY_VALID}, 4'd0);
      checkOutput("reset_held", {3'b0, KEY_HELD}, 4'd0);
      checkOutput("reset_code", KEY_CODE, 4'd0);
      RST_N = 1'b1;
      applyStimulus(16'h0); checkOutput("idle_col1", COL_OUT, 4'b1101);
      applyStimulus(16'h0); checkOutput("idle_col2", COL_OUT, 4'b1011);
      applyStimulus(16'h0); checkOutput("idle_col3", COL_OUT, 4'b0111);
      applyStimulus(16'h0); checkOutput("idle_col0", COL_OUT, 4'b1110);

      // Clean press of row 2 / col 1, held for 20 ticks
      exp_q.push_back(4'd9);
      applyStimulus(16'h0200);
      checkOutput("press_col", COL_OUT, 4'b1101);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'h0200);
         checkOutput("press_held", {3'b0, KEY_HELD}, (i >= 3) ? 4'd1 : 4'd0);
         checkOutput("press_frozen", COL_OUT, 4'b1101);
         if (i == 3) begin
            checkOutput("accept_valid", {3'b0, KEY_VALID}, 4'd1);
            checkOutput("accept_code", KEY_CODE, 4'd9);
            @(posedge CLK);
            #1 checkOutput("valid_clears", {3'b0, KEY_VALID}, 4'd0);
         end
      end

      // Release bounce: high 2 ticks, low again, then a real release
      applyStimulus(16'h0); applyStimulus(16'h0);
      checkOutput("rel_bounce_held", {3'b0, KEY_HELD}, 4'd1);
      applyStimulus(16'h0200);
      checkOutput("rel_rehold_held", {3'b0, KEY_HELD}, 4'd1);
      checkOutput("rel_rehold_col", COL_OUT, 4'b1101);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0);
         checkOutput("release_held", {3'b0, KEY_HELD}, (i == 3) ? 4'd0 : 4'd1);
      end
      checkOutput("release_col", COL_OUT, 4'b1011);
      applyStimulus(16'h0);
      checkOutput("release_rotate", COL_OUT, 4'b0111);

      // Press bounce on row 2 / col 1
      applyStimulus(16'h0);
      applyStimulus(16'h0);
      checkOutput("bounce_start_col", COL_OUT, 4'b1101);
      applyStimulus(16'h0200);
      applyStimulus(16'h0200);
      applyStimulus(16'h0);
      checkOutput("bounce_held", {3'b0, KEY_HELD}, 4'd0);
      checkOutput("bounce_col", COL_OUT, 4'b1011);

      // Two keys in col 2 (rows 0 and 3): row 0 wins
      exp_q.push_back(4'd2);
      for (int i = 0; i < 4; i++) applyStimulus(16'h4004);
      checkOutput("two_key_held", {3'b0, KEY_HELD}, 4'd1);
      checkOutput("two_key_code", KEY_CODE, 4'd2);
      checkOutput("two_key_col", COL_OUT, 4'b1011);
      for (int i = 0; i < 4; i++) applyStimulus(16'h0);
      checkOutput("two_key_rel_held", {3'b0, KEY_HELD}, 4'd0);
      checkOutput("two_key_rel_col", COL_OUT, 4'b0111);

      // Reset in the middle of debouncing row 1 / col 3
      applyStimulus(16'h0080);
      applyStimulus(16'h0080);
      RST_N = 1'b0;
      #1;
      checkOutput("midrst_col", COL_OUT, 4'b1110);
      checkOutput("midrst_held", {3'b0, KEY_HELD}, 4'd0);
      checkOutput("midrst_valid", {3'b0, KEY_VALID}, 4'd0);
      checkOutput("midrst_code", KEY_CODE, 4'd2 & 4'd0);
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      exp_q.push_back(4'd7);
      for (int i = 0; i < 3; i++) applyStimulus(16'h0080);
      checkOutput("redetect_col", COL_OUT, 4'b0111);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'h0080);
         checkOutput("redetect_held", {3'b0, KEY_HELD}, (i == 3) ? 4'd1 : 4'd0);
      end
      checkOutput("redetect_code", KEY_CODE, 4'd7);

      repeat (4) @(posedge CLK);
      #1;
      checkOutput("pending_expected", 4'(exp_q.size()), 4'd0);
      checkOutput("valid_count", 4'(valids_seen), 4'd3);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
